// File: rtl/fab_int_ccc_lock_ctrl.sv
// CCC PLL lock supervisor: pulses PLL reset, qualifies LOCK,
// then releases the GL0 fabric reset; retries on timeout.
module fab_int_ccc_lock_ctrl #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 40000,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 16,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  LOCK,
  input  logic                  CLR_LOST,
  output logic                  PLL_ARST_N,
  output logic                  FABRIC_RESET_N,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
  output logic                  FAIL
);

  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // entry to STABLE already accounts for the first sample
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 2);
  localparam logic [RTY_W-1:0] RTY_MAX =
    RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [RTY_W-1:0]      r_rty;
  logic [1:0]            r_sync;
  logic                  r_pll_arst_n;
  logic                  r_fab_rst_n;
  logic                  r_ready;
  logic                  r_lost;
  logic [LOSS_CNT_W-1:0] r_loss;
  logic                  r_fail;
  logic                  w_lock_s;

  assign w_lock_s = r_sync[1];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_rty        <= '0;
      r_sync       <= '0;
      r_pll_arst_n <= 1'b0;
      r_fab_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_lost       <= 1'b0;
      r_loss       <= '0;
      r_fail       <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], LOCK};
      // a loss event below overrides this clear
      if (CLR_LOST) r_lost <= 1'b0;
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == HOLD_LAST) begin
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_pll_arst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TMO_LAST) begin
            r_cnt <= '0;
            if (r_rty == RTY_MAX) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_rty        <= r_rty + 1'b1;
              r_state      <= S_PLL_RST;
              r_pll_arst_n <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STB_LAST) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_rty       <= '0;
            r_fab_rst_n <= 1'b1;
            r_ready     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_fab_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_lost      <= 1'b1;
            if (r_loss != '1) r_loss <= r_loss + 1'b1;
          end
        end
        S_FAIL: begin
          r_cnt <= '0;
        end
        default: begin
          r_state      <= S_PLL_RST;
          r_cnt        <= '0;
          r_pll_arst_n <= 1'b0;
          r_fab_rst_n  <= 1'b0;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign PLL_ARST_N     = r_pll_arst_n;
  assign FABRIC_RESET_N = r_fab_rst_n;
  assign READY          = r_ready;
  assign LOCK_LOST      = r_lost;
  assign LOSS_COUNT     = r_loss;
  assign FAIL           = r_fail;

endmodule

// File: tb/tb_fab_int_ccc_lock_ctrl.sv
// Bench for fab_int_ccc_lock_ctrl: directed scenarios plus
// random LOCK/CLR_LOST/RESET_N traffic against a behavioural model.
module tb_fab_int_ccc_lock_ctrl;

  localparam int N    = 8;
  localparam int TMO  = 50;
  localparam int HOLD = 4;
  localparam int MAXR = 2;
  localparam int LW   = 2;
  localparam int LSAT = (1 << LW) - 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          LOCK = 1'b0;
  logic          CLR_LOST = 1'b0;
  logic          PLL_ARST_N;
  logic          FABRIC_RESET_N;
  logic          READY;
  logic          LOCK_LOST;
  logic [LW-1:0] LOSS_COUNT;
  logic          FAIL;

  int n_tests = 0;
  int n_fail  = 0;

  fab_int_ccc_lock_ctrl #(
    .LOCK_STABLE_CYCLES (N),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .RST_HOLD_CYCLES    (HOLD),
    .MAX_RETRIES        (MAXR),
    .CNT_W              (16),
    .LOSS_CNT_W         (LW)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .LOCK          (LOCK),
    .CLR_LOST      (CLR_LOST),
    .PLL_ARST_N    (PLL_ARST_N),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .READY         (READY),
    .LOCK_LOST     (LOCK_LOST),
    .LOSS_COUNT    (LOSS_COUNT),
    .FAIL          (FAIL)
  );

  always #5 CLK = ~CLK;

  // behavioural model: phases with natural run-length counters
  typedef enum {M_RST, M_WAIT, M_STB, M_RUN, M_FAIL} mph_t;
  mph_t ph = M_RST;
  int   hold_left = HOLD;
  int   waited = 0;
  int   seen = 0;
  int   retries = 0;
  int   losses = 0;
  bit   lost = 1'b0;
  bit   s1 = 1'b0;
  bit   s2 = 1'b0;

  task automatic model_step();
    bit ls;
    bit set_ev;
    ls = s2;
    s2 = s1;
    s1 = LOCK;
    set_ev = 1'b0;
    if (!RESET_N) begin
      ph = M_RST; hold_left = HOLD; waited = 0; seen = 0;
      retries = 0; losses = 0; lost = 1'b0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      case (ph)
        M_RST: begin
          hold_left--;
          if (hold_left == 0) begin ph = M_WAIT; waited = 0; end
        end
        M_WAIT: begin
          if (ls) begin
            ph = M_STB; seen = 1;
          end else begin
            waited++;
            if (waited == TMO) begin
              if (retries == MAXR) ph = M_FAIL;
              else begin retries++; ph = M_RST; hold_left = HOLD; end
            end
          end
        end
        M_STB: begin
          if (!ls) begin
            ph = M_WAIT; waited = 0;
          end else begin
            seen++;
            if (seen == N) begin ph = M_RUN; retries = 0; end
          end
        end
        M_RUN: begin
          if (!ls) begin
            ph = M_WAIT; waited = 0; set_ev = 1'b1; lost = 1'b1;
            if (losses < LSAT) losses++;
          end
        end
        default: ;
      endcase
      if (CLR_LOST && !set_ev) lost = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    CLR_LOST = 1'b0;
    tick();
    tick();
  endtask

  // counts observations of PLL_ARST_N low, starting with the current one
  task automatic count_pll_low(output int lows);
    lows = 0;
    RESET_N = 1'b1;
    for (int i = 0; i < 20 && !PLL_ARST_N; i++) begin
      lows++;
      tick();
    end
  endtask

  // edges until READY equals lvl, bounded
  task automatic edges_to_ready(input logic lvl, output int edges);
    edges = 0;
    while (READY !== lvl && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    int lows;
    LOCK = 1'b0;
    do_reset();
    n_tests++;
    if ({PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
         LOSS_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: got %b%b%b%b%b %0d want all 0",
               PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
               LOSS_COUNT);
    end
    count_pll_low(lows);
    n_tests++;
    if (lows != HOLD) begin
      n_fail++;
      $display("FAIL reset_pulse: got %0d want %0d", lows, HOLD);
    end
  endtask

  task automatic test_lock_release();
    int e;
    LOCK = 1'b1;
    edges_to_ready(1'b1, e);
    n_tests++;
    if (e != N + 2) begin
      n_fail++;
      $display("FAIL release_lat: got %0d want %0d", e, N + 2);
    end
    n_tests++;
    if (FABRIC_RESET_N !== 1'b1 || LOSS_COUNT !== '0) begin
      n_fail++;
      $display("FAIL release_outs: fab=%b loss=%0d want 1 0",
               FABRIC_RESET_N, LOSS_COUNT);
    end
  endtask

  task automatic test_glitch();
    int lows;
    int e;
    bit early;
    LOCK = 1'b0;
    do_reset();
    count_pll_low(lows);
    early = 1'b0;
    LOCK = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); early |= READY; end
    LOCK = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); early |= READY; end
    LOCK = 1'b1;
    edges_to_ready(1'b1, e);
    n_tests++;
    if (early || e != N + 2) begin
      n_fail++;
      $display("FAIL glitch_release: early=%0d edges=%0d want 0 %0d",
               early, e, N + 2);
    end
    n_tests++;
    if (LOCK_LOST !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_lost: got %b want 0", LOCK_LOST);
    end
  endtask

  task automatic test_loss_clear();
    int e;
    bit pll_dip;
    LOCK = 1'b0;
    edges_to_ready(1'b0, e);
    n_tests++;
    if (e != 3) begin
      n_fail++;
      $display("FAIL loss_lat: got %0d want 3", e);
    end
    n_tests++;
    if ({LOCK_LOST, LOSS_COUNT, PLL_ARST_N, FABRIC_RESET_N} !==
        {1'b1, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL loss_outs: lost=%b cnt=%0d pll=%b fab=%b want 1 1 1 0",
               LOCK_LOST, LOSS_COUNT, PLL_ARST_N, FABRIC_RESET_N);
    end
    pll_dip = 1'b0;
    LOCK = 1'b1;
    e = 0;
    while (READY !== 1'b1 && e < 200) begin
      tick();
      e++;
      pll_dip |= !PLL_ARST_N;
    end
    n_tests++;
    if (e != N + 2 || pll_dip || LOCK_LOST !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: edges=%0d dip=%0d lost=%b want %0d 0 1",
               e, pll_dip, LOCK_LOST, N + 2);
    end
    CLR_LOST = 1'b1;
    tick();
    CLR_LOST = 1'b0;
    n_tests++;
    if (LOCK_LOST !== 1'b0 || READY !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_lost: lost=%b ready=%b want 0 1",
               LOCK_LOST, READY);
    end
  endtask

  task automatic test_saturate();
    int lows;
    int e;
    int exp_l[4] = '{1, 2, 3, 3};
    LOCK = 1'b0;
    do_reset();
    count_pll_low(lows);
    for (int k = 0; k < 4; k++) begin
      LOCK = 1'b1;
      edges_to_ready(1'b1, e);
      LOCK = 1'b0;
      tick();
      tick();
      if (k == 3) CLR_LOST = 1'b1;
      tick();
      CLR_LOST = 1'b0;
      n_tests++;
      if (READY !== 1'b0 || LOCK_LOST !== 1'b1 ||
          LOSS_COUNT !== LW'(exp_l[k])) begin
        n_fail++;
        $display("FAIL saturate_%0d: ready=%b lost=%b cnt=%0d want 0 1 %0d",
                 k, READY, LOCK_LOST, LOSS_COUNT, exp_l[k]);
      end
    end
  endtask

  task automatic test_timeout_fail();
    int lows;
    int pulses;
    int fail_at;
    bit prev;
    bit bad;
    LOCK = 1'b0;
    do_reset();
    RESET_N = 1'b1;
    lows = 0; pulses = 0; fail_at = -1; prev = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (FAIL === 1'b1) begin fail_at = i; break; end
      if (!PLL_ARST_N) lows++;
      if (!PLL_ARST_N && prev) pulses++;
      prev = PLL_ARST_N;
      tick();
    end
    n_tests++;
    if (pulses != MAXR + 1 || lows != HOLD * (MAXR + 1)) begin
      n_fail++;
      $display("FAIL retry_pulses: pulses=%0d lows=%0d want %0d %0d",
               pulses, lows, MAXR + 1, HOLD * (MAXR + 1));
    end
    n_tests++;
    if (fail_at != (MAXR + 1) * (HOLD + TMO) || PLL_ARST_N !== 1'b1) begin
      n_fail++;
      $display("FAIL fail_time: at=%0d pll=%b want %0d 1",
               fail_at, PLL_ARST_N, (MAXR + 1) * (HOLD + TMO));
    end
    LOCK = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      bad |= READY | FABRIC_RESET_N | !FAIL | !PLL_ARST_N;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL fail_sticky: got disturbance=1 want 0");
    end
    do_reset();
    n_tests++;
    if (FAIL !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_clear: got %b want 0", FAIL);
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    int e;
    LOCK = 1'b1;
    do_reset();
    count_pll_low(lows);
    tick();
    tick();
    tick();
    RESET_N = 1'b0;
    tick();
    n_tests++;
    if ({PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
         LOSS_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL mid_stable_rst: got %b%b%b%b%b %0d want all 0",
               PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
               LOSS_COUNT);
    end
    count_pll_low(lows);
    n_tests++;
    if (lows != HOLD) begin
      n_fail++;
      $display("FAIL mid_stable_pulse: got %0d want %0d", lows, HOLD);
    end
    edges_to_ready(1'b1, e);
    LOCK = 1'b0;
    edges_to_ready(1'b0, e);
    LOCK = 1'b1;
    edges_to_ready(1'b1, e);
    n_tests++;
    if (READY !== 1'b1 || LOCK_LOST !== 1'b1 || LOSS_COUNT !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_run_setup: ready=%b lost=%b cnt=%0d want 1 1 1",
               READY, LOCK_LOST, LOSS_COUNT);
    end
    RESET_N = 1'b0;
    tick();
    n_tests++;
    if ({PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
         LOSS_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL mid_run_rst: got %b%b%b%b%b %0d want all 0",
               PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
               LOSS_COUNT);
    end
    count_pll_low(lows);
    n_tests++;
    if (lows != HOLD) begin
      n_fail++;
      $display("FAIL mid_run_pulse: got %0d want %0d", lows, HOLD);
    end
  endtask

  task automatic test_random();
    int run_left;
    logic [LW+4:0] got;
    logic [LW+4:0] exp;
    int errs;
    LOCK = 1'b0;
    do_reset();
    RESET_N = 1'b1;
    run_left = 0;
    errs = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (run_left == 0) begin
        LOCK = 1'($urandom % 2);
        run_left = LOCK ? $urandom_range(1, 40) : $urandom_range(1, 70);
      end
      run_left--;
      CLR_LOST = ($urandom % 16) == 0;
      RESET_N = ($urandom % 600) != 0;
      tick();
      got = {PLL_ARST_N, FABRIC_RESET_N, READY, LOCK_LOST, FAIL,
             LOSS_COUNT};
      exp = {ph != M_RST, ph == M_RUN, ph == M_RUN, lost, ph == M_FAIL,
             LW'(losses)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 20)
          $display("FAIL random_cyc%0d: got %b want %b", cyc, got, exp);
      end
    end
    CLR_LOST = 1'b0;
    RESET_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_release();
    test_glitch();
    test_loss_clear();
    test_saturate();
    test_timeout_fail();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
